// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: buffers 64 coefficients, then produces each pixel with a
// 64-term multiply-accumulate over the Q8 cosine basis, level-shifted and clamped to 8 bits.
module idct_8x8_serial (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [11:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [7:0]         m_data,
    output logic               m_last
);

    localparam int DATA_W = 12;
    localparam int COEF_W = 8;
    localparam int BASE_W = 2 * COEF_W;
    localparam int PROD_W = DATA_W + BASE_W;
    localparam int ACC_W  = 36;

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    state_t state, state_nx;

    logic                     load_en;
    logic [5:0]               cidx;
    logic [5:0]               pidx;
    logic [6:0]               cnt;
    logic                     accept;
    logic                     issue;
    logic                     calc_done;

    logic signed [DATA_W-1:0] coef [64];

    logic signed [COEF_W-1:0] t_row;
    logic signed [COEF_W-1:0] t_col;

    logic signed [DATA_W-1:0] coef_p1;
    logic signed [BASE_W-1:0] b_p1;
    logic                     vld_p1;

    logic signed [PROD_W-1:0] prod_p2;
    logic                     vld_p2;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;

    // 1D basis via the half-period symmetry T[k][7-n] = (-1)^k * T[k][n]
    function automatic logic signed [COEF_W-1:0] t_rom(input logic [2:0] k, input logic [2:0] n);
        logic [31:0]              row;
        logic [2:0]               m;
        logic signed [COEF_W-1:0] v;
        m = n[2] ? ~n : n;
        case (k)
            3'd0:    row = 32'h5B5B5B5B;
            3'd1:    row = 32'h19476A7E;
            3'd2:    row = 32'h8ACF3176;
            3'd3:    row = 32'hB982E76A;
            3'd4:    row = 32'h5BA5A55B;
            3'd5:    row = 32'h6A198247;
            3'd6:    row = 32'hCF768A31;
            default: row = 32'h826AB919;
        endcase
        v = row[m[1:0]*8 +: 8];
        if (n[2] && k[0]) v = -v;
        return v;
    endfunction

    function automatic logic [7:0] sat_pixel(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] rnd;
        logic signed [19:0]      r;
        logic signed [20:0]      p;
        rnd = a + 36'sd32768;
        r   = rnd[35:16];
        p   = {r[19], r} + 21'sd128;
        if (p < 21'sd0)        return 8'd0;
        else if (p > 21'sd255) return 8'd255;
        else                   return p[7:0];
    endfunction

    assign accept    = s_valid & s_ready;
    assign issue     = (state == CALC) && !cnt[6];
    assign calc_done = (state == CALC) && (cnt == 7'd65);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            load_en <= 1'b0;
        end else begin
            state   <= state_nx;
            load_en <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (accept && cidx == 6'd63) state_nx = CALC;
            CALC: if (calc_done)               state_nx = EMIT;
            EMIT: if (m_ready)                 state_nx = (pidx == 6'd63) ? LOAD : CALC;
            default:                           state_nx = LOAD;
        endcase
    end

    always_comb begin
        s_ready = (state == LOAD) && load_en;
        m_valid = (state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cidx <= 6'd0;
            pidx <= 6'd0;
            cnt  <= 7'd0;
        end else begin
            if (accept) cidx <= cidx + 6'd1;
            cnt <= (state == CALC) ? cnt + 7'd1 : 7'd0;
            if (state == EMIT && m_ready) pidx <= pidx + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) coef[cidx] <= s_data;
    end

    always_comb begin
        t_row = t_rom(cnt[5:3], pidx[5:3]);
        t_col = t_rom(cnt[2:0], pidx[2:0]);
    end

    // stage 1: coefficient fetch and 2D basis product
    always_ff @(posedge clk) begin
        coef_p1 <= coef[cnt[5:0]];
        b_p1    <= BASE_W'(t_row) * BASE_W'(t_col);
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= issue;
    end

    // stage 2: registered term coef * B
    always_ff @(posedge clk) begin
        prod_p2 <= PROD_W'(coef_p1) * PROD_W'(b_p1);
        if (reset) vld_p2 <= 1'b0;
        else       vld_p2 <= vld_p1;
    end

    // accumulate; the final term is folded in combinationally on the last CALC cycle
    assign acc_sum = acc + (vld_p2 ? ACC_W'(prod_p2) : 36'sd0);

    always_ff @(posedge clk) begin
        if (reset || state != CALC) acc <= 36'sd0;
        else                        acc <= acc_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_data <= 8'd0;
            m_last <= 1'b0;
        end else if (calc_done) begin
            m_data <= sat_pixel(acc_sum);
            m_last <= (pidx == 6'd63);
        end
    end

endmodule
